ahb_ap_master: RTL and testbench

- Parametrised, command-driven AHB-Lite master access point; next generation of the JTAG AHB access point.
- Pops command packets from the JTAG-side request FIFO (FIFO1) and issues single AHB-Lite transfers.
- Pushes read data and status into the response FIFO (FIFO2).
- Adds over the previous generation: configurable transfer size, address auto-increment, alignment checking, a sticky bus-error flag, and a status bit on every response.

---
 rtl/ahb_ap_master.sv | 167 ++++++++++++++++
 tb/tb_ahb_ap_master.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_ap_master.sv
// Command-driven AHB-Lite master access point: pops {cmd,payload} packets, runs single transfers, pushes {err,data}.
// Build option AHB_AP_WRITE_ACK_EN: writes also push an {err,0} acknowledgement.
module ahb_ap_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CMD_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rempty,
  input  logic [CMD_W+DATA_W-1:0] rdata_fifo1,
  output logic                    rinc,
  input  logic                    wfull,
  output logic [DATA_W:0]         wdata_fifo2,
  output logic                    winc,
  output logic [ADDR_W-1:0]       HADDR,
  output logic                    HWRITE,
  output logic [2:0]              HSIZE,
  output logic [1:0]              HTRANS,
  output logic [DATA_W-1:0]       HWDATA,
  input  logic [DATA_W-1:0]       HRDATA,
  input  logic                    HREADY,
  input  logic                    HRESP,
  output logic                    busy,
  output logic                    err_sticky
);

`ifdef AHB_AP_WRITE_ACK_EN
  localparam bit WR_ACK = 1'b1;
`else
  localparam bit WR_ACK = 1'b0;
`endif

  localparam logic [CMD_W-1:0]  CMD_SET_ADDR = CMD_W'(1);
  localparam logic [CMD_W-1:0]  CMD_SET_CFG  = CMD_W'(2);
  localparam logic [CMD_W-1:0]  CMD_WRITE    = CMD_W'(3);
  localparam logic [CMD_W-1:0]  CMD_READ     = CMD_W'(4);
  localparam logic [CMD_W-1:0]  CMD_CLR_ERR  = CMD_W'(5);
  localparam logic [ADDR_W-1:0] ADDR_ONE     = ADDR_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

  state_t              state, nxt;
  logic [CMD_W-1:0]    cmd;
  logic [DATA_W-1:0]   payload;
  logic [ADDR_W-1:0]   addr;
  logic [1:0]          size;
  logic                autoinc;
  logic                is_wr;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W:0]     rd;
  logic                err_q;
  logic [2:0]          amask;
  logic                misalign;
  logic                cfg_bad;

  assign {cmd, payload} = rdata_fifo1;

  always_comb begin
    case (size)
      2'd0:    amask = 3'b000;
      2'd1:    amask = 3'b001;
      2'd2:    amask = 3'b011;
      default: amask = 3'b111;
    endcase
  end

  assign misalign = |(addr[2:0] & amask);
  // a doubleword transfer cannot exist on a 32-bit bus
  assign cfg_bad  = (DATA_W == 32) && (payload[1:0] == 2'b11);

  assign HADDR       = addr;
  assign HWDATA      = wdata;
  assign wdata_fifo2 = rd;
  assign err_sticky  = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: if (!rempty) begin
        if (cmd == CMD_WRITE)     nxt = misalign ? (WR_ACK ? S_RESP : S_IDLE) : S_ADDR;
        else if (cmd == CMD_READ) nxt = misalign ? S_RESP : S_ADDR;
      end
      S_ADDR: if (HREADY) nxt = S_DATA;
      S_DATA: if (HREADY) nxt = (is_wr && !WR_ACK) ? S_IDLE : S_RESP;
      S_RESP: if (!wfull) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    rinc   = 1'b0;
    winc   = 1'b0;
    HTRANS = 2'b00;
    HWRITE = 1'b0;
    HSIZE  = 3'b000;
    busy   = 1'b1;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        rinc = !rempty;
      end
      S_ADDR: begin
        HTRANS = 2'b10;
        HWRITE = is_wr;
        HSIZE  = {1'b0, size};
      end
      // HTRANS stays IDLE here, which also covers both cycles of an ERROR response
      S_DATA: begin
        HWRITE = is_wr;
        HSIZE  = {1'b0, size};
      end
      S_RESP: winc = !wfull;
      default: busy = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr    <= '0;
      size    <= 2'd2;
      autoinc <= 1'b0;
      is_wr   <= 1'b0;
      wdata   <= '0;
      rd      <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (!rempty) begin
          case (cmd)
            CMD_SET_ADDR: addr <= payload[ADDR_W-1:0];
            CMD_SET_CFG: begin
              if (cfg_bad) err_q <= 1'b1;
              else begin
                size    <= payload[1:0];
                autoinc <= payload[2];
              end
            end
            CMD_WRITE, CMD_READ: begin
              is_wr <= (cmd == CMD_WRITE);
              if (cmd == CMD_WRITE) wdata <= payload;
              if (misalign) begin
                err_q <= 1'b1;
                rd    <= {1'b1, {DATA_W{1'b0}}};
              end
            end
            CMD_CLR_ERR: err_q <= 1'b0;
            default:     err_q <= 1'b1;
          endcase
        end
        S_DATA: if (HREADY) begin
          rd <= is_wr ? {HRESP, {DATA_W{1'b0}}} : {HRESP, HRDATA};
          if (HRESP)   err_q <= 1'b1;
          // increments on error too; wraps modulo the address width
          if (autoinc) addr  <= addr + (ADDR_ONE << size);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_ap_master.sv
// Randomized bench for ahb_ap_master: request/response FIFOs and an AHB slave modelled here, checked against a command-level reference.
module tb_ahb_ap_master;
  localparam int AW = 32, DW = 32, CW = 4;

`ifdef AHB_AP_WRITE_ACK_EN
  localparam bit ACK = 1'b1;
`else
  localparam bit ACK = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } xfer_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rempty, rinc, wfull = 1'b0, winc, HWRITE, HREADY, HRESP, busy, err_sticky;
  logic [CW+DW-1:0] rdata_fifo1;
  logic [DW:0] wdata_fifo2;
  logic [AW-1:0] HADDR;
  logic [2:0] HSIZE;
  logic [1:0] HTRANS;
  logic [DW-1:0] HWDATA, HRDATA;

  always #5 clk = ~clk;

  ahb_ap_master #(.ADDR_W(AW), .DATA_W(DW), .CMD_W(CW)) dut (
    .clk(clk), .rst(rst), .rempty(rempty), .rdata_fifo1(rdata_fifo1), .rinc(rinc),
    .wfull(wfull), .wdata_fifo2(wdata_fifo2), .winc(winc), .HADDR(HADDR), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HTRANS(HTRANS), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY),
    .HRESP(HRESP), .busy(busy), .err_sticky(err_sticky)
  );

  int checks = 0, errors = 0;

  function automatic logic [31:0] init_val(int i);
    return 32'hA500_0000 ^ (i * 32'h0103_0507);
  endfunction

  // request FIFO: written by the stimulus, read pointer advanced by the monitor
  logic [35:0] fq_mem [0:1023];
  int wr_cnt = 0, rd_ptr = 0;
  always_comb begin
    rempty      = (rd_ptr == wr_cnt);
    rdata_fifo1 = fq_mem[rd_ptr % 1024];
  end

  logic pop_f = 1'b0, push_f = 1'b0;
  logic [32:0] push_v = '0;
  int cyc = 0;
  logic [32:0] obs_r[$];
  int pop_cyc[$], push_cyc[$];

  always @(negedge clk) begin
    pop_f  <= rinc & ~rst;
    push_f <= winc & ~wfull & ~rst;
    push_v <= wdata_fifo2;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    #1;
    if (rst) rd_ptr <= wr_cnt;
    else begin
      if (pop_f) begin
        rd_ptr <= rd_ptr + 1;
        pop_cyc.push_back(cyc);
      end
      if (push_f) begin
        obs_r.push_back(push_v);
        push_cyc.push_back(cyc);
      end
    end
  end

  // AHB slave: word memory, programmable wait states and two-cycle ERROR
  logic dphase = 1'b0, dwrite = 1'b0;
  logic [31:0] daddr = '0;
  logic [2:0] dsize = '0;
  int dcnt = 0, waits = 0;
  bit err_mode = 1'b0;
  logic [31:0] mem [0:255];
  xfer_t obs_x[$];

  always_comb begin
    HREADY = 1'b1;
    HRESP  = 1'b0;
    if (dphase) begin
      if (dcnt < waits) HREADY = 1'b0;
      else if (err_mode && dcnt == waits) begin
        HREADY = 1'b0;
        HRESP  = 1'b1;
      end else HRESP = err_mode;
    end
    HRDATA = mem[daddr[9:2]];
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      dphase <= 1'b0;
      dcnt   <= 0;
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
    end else begin
      if (dphase && HREADY) begin
        obs_x.push_back(xfer_t'({daddr, dwrite, dsize, dwrite ? HWDATA : 32'h0}));
        if (dwrite && !HRESP) mem[daddr[9:2]] <= HWDATA;
      end
      if (HREADY) begin
        dphase <= (HTRANS == 2'b10);
        daddr  <= HADDR;
        dwrite <= HWRITE;
        dsize  <= HSIZE;
        dcnt   <= 0;
      end else dcnt <= dcnt + 1;
    end
  end

  // command-level reference model
  logic [31:0] m_addr;
  logic [1:0]  m_size;
  bit          m_inc, m_err;
  logic [31:0] mem_ref [0:255];
  xfer_t       exp_x[$];
  logic [32:0] exp_r[$];

  task automatic model_reset();
    m_addr = 0; m_size = 2; m_inc = 0; m_err = 0;
    for (int i = 0; i < 256; i++) mem_ref[i] = init_val(i);
  endtask

  task automatic model_cmd(logic [3:0] c, logic [31:0] p);
    bit wr;
    logic [31:0] rdat;
    case (c)
      4'd1: m_addr = p;
      4'd2: if (p[1:0] == 2'd3) m_err = 1; else begin m_size = p[1:0]; m_inc = p[2]; end
      4'd3, 4'd4: begin
        wr = (c == 4'd3);
        if ((m_addr % (32'd1 << m_size)) != 0) begin
          m_err = 1;
          if (!wr || ACK) exp_r.push_back({1'b1, 32'h0});
        end else begin
          exp_x.push_back(xfer_t'({m_addr, wr, 1'b0, m_size, wr ? p : 32'h0}));
          rdat = mem_ref[m_addr[9:2]];
          if (err_mode) m_err = 1;
          if (wr && !err_mode) mem_ref[m_addr[9:2]] = p;
          if (!wr) exp_r.push_back({err_mode, rdat});
          else if (ACK) exp_r.push_back({err_mode, 32'h0});
          if (m_inc) m_addr = m_addr + (32'd1 << m_size);
        end
      end
      4'd5: m_err = 0;
      default: m_err = 1;
    endcase
  endtask

  task automatic send(logic [3:0] c, logic [31:0] p);
    model_cmd(c, p);
    fq_mem[wr_cnt % 1024] = {c, p};
    wr_cnt++;
  endtask

  task automatic step();
    @(posedge clk); #2;
  endtask

  function automatic bit idle_now();
    return rempty && !busy && !rinc;
  endfunction

  task automatic drain(output bit ok);
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (idle_now()) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    @(negedge clk);
    checks++; if (HTRANS !== 2'b00) begin errors++; $display("FAIL reset_htrans: got %0h want 0", HTRANS); end
    checks++; if ({rinc, winc, busy, err_sticky} !== 4'b0) begin errors++; $display("FAIL reset_ctrl: got %b want 0000", {rinc, winc, busy, err_sticky}); end
    checks++; if (HADDR !== 32'h0) begin errors++; $display("FAIL reset_haddr: got %h want 0", HADDR); end
    checks++; if (wdata_fifo2 !== 33'h0) begin errors++; $display("FAIL reset_wdata2: got %h want 0", wdata_fifo2); end
    model_reset();
    step();
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int bx, br, er;
    bit ok;
    step();
    bx = obs_x.size(); br = obs_r.size(); er = exp_r.size();
    send(1, 32'h1000); send(2, 32'h6); send(3, 32'hDEADBEEF); send(4, 0);
    drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout: got busy want idle"); end
    checks++; if (obs_x.size() - bx != 2) begin errors++; $display("FAIL basic_nxfer: got %0d want 2", obs_x.size() - bx); end
    else begin
      checks++; if ({obs_x[bx].addr, obs_x[bx].wr, obs_x[bx].wdata} !== {32'h1000, 1'b1, 32'hDEADBEEF})
        begin errors++; $display("FAIL basic_write: got %h/%b/%h want 1000/1/deadbeef", obs_x[bx].addr, obs_x[bx].wr, obs_x[bx].wdata); end
      checks++; if ({obs_x[bx+1].addr, obs_x[bx+1].wr} !== {32'h1004, 1'b0})
        begin errors++; $display("FAIL basic_read_addr: got %h/%b want 1004/0", obs_x[bx+1].addr, obs_x[bx+1].wr); end
    end
    checks++; if (obs_r.size() - br != exp_r.size() - er) begin errors++; $display("FAIL basic_nresp: got %0d want %0d", obs_r.size() - br, exp_r.size() - er); end
    else begin
      checks++; if (obs_r[obs_r.size()-1] !== {1'b0, init_val(1)}) begin errors++; $display("FAIL basic_rdata: got %h want %h", obs_r[obs_r.size()-1], {1'b0, init_val(1)}); end
    end
    checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL basic_err: got %b want 0", err_sticky); end
  endtask

  task automatic test_latency();
    int bp, bw;
    bit ok;
    step();
    bp = pop_cyc.size(); bw = push_cyc.size();
    send(4, 0); send(3, 32'h1234_5678); send(5, 0);
    drain(ok);
    checks++; if (!ok || pop_cyc.size() - bp != 3 || push_cyc.size() - bw < 1) begin
      errors++; $display("FAIL latency_events: got pops %0d pushes %0d want 3 and >=1", pop_cyc.size() - bp, push_cyc.size() - bw);
    end else begin
      checks++; if (push_cyc[bw] - pop_cyc[bp] != 3) begin errors++; $display("FAIL latency_read_winc: got %0d want 3", push_cyc[bw] - pop_cyc[bp]); end
      checks++; if (pop_cyc[bp+1] - pop_cyc[bp] != 4) begin errors++; $display("FAIL latency_read_next: got %0d want 4", pop_cyc[bp+1] - pop_cyc[bp]); end
      checks++; if (pop_cyc[bp+2] - pop_cyc[bp+1] != (ACK ? 4 : 3)) begin errors++; $display("FAIL latency_write_next: got %0d want %0d", pop_cyc[bp+2] - pop_cyc[bp+1], ACK ? 4 : 3); end
    end
  endtask

  task automatic test_wait_states();
    int br, er, nw;
    bit ok;
    step();
    waits = 3; br = obs_r.size(); er = exp_r.size(); nw = 0; ok = 0;
    send(1, 32'h100); send(2, 32'h2); send(4, 0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!HREADY) begin
        nw++;
        checks++; if ({HTRANS, HWRITE, HADDR} !== {2'b00, 1'b0, 32'h100})
          begin errors++; $display("FAIL wait_stable: got %0h/%b/%h want 0/0/100", HTRANS, HWRITE, HADDR); end
      end
      if (idle_now()) begin ok = 1; break; end
    end
    waits = 0;
    checks++; if (!ok || nw != 3) begin errors++; $display("FAIL wait_cycles: got %0d want 3", nw); end
    checks++; if (obs_r.size() - br != 1) begin errors++; $display("FAIL wait_nresp: got %0d want 1", obs_r.size() - br); end
    else begin
      checks++; if (obs_r[br] !== exp_r[er]) begin errors++; $display("FAIL wait_rdata: got %h want %h", obs_r[br], exp_r[er]); end
    end
  endtask

  task automatic test_error();
    int br, ne;
    bit ok;
    step();
    err_mode = 1; br = obs_r.size(); ne = 0; ok = 0;
    send(5, 0); send(1, 32'h80); send(4, 0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (HRESP) begin
        ne++;
        checks++; if (HTRANS !== 2'b00) begin errors++; $display("FAIL error_htrans: got %0h want 0", HTRANS); end
      end
      if (idle_now()) begin ok = 1; break; end
    end
    err_mode = 0;
    checks++; if (!ok || ne != 2) begin errors++; $display("FAIL error_cycles: got %0d want 2", ne); end
    checks++; if (obs_r.size() - br != 1) begin errors++; $display("FAIL error_nresp: got %0d want 1", obs_r.size() - br); end
    else begin
      checks++; if (obs_r[br][32] !== 1'b1) begin errors++; $display("FAIL error_resp_bit: got %b want 1", obs_r[br][32]); end
    end
    checks++; if (err_sticky !== 1'b1) begin errors++; $display("FAIL error_sticky_set: got %b want 1", err_sticky); end
    step();
    send(5, 0);
    drain(ok);
    checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL error_sticky_clr: got %b want 0", err_sticky); end
  endtask

  task automatic test_misaligned();
    int bx, br, ex, er;
    bit ok;
    step();
    bx = obs_x.size(); br = obs_r.size(); ex = exp_x.size(); er = exp_r.size();
    send(2, 32'h1); send(1, 32'h3); send(4, 0); send(3, 32'h55); send(2, 32'h0); send(4, 0);
    drain(ok);
    checks++; if (obs_x.size() - bx != 1) begin errors++; $display("FAIL misalign_nxfer: got %0d want 1", obs_x.size() - bx); end
    else begin
      checks++; if ({obs_x[bx].addr, obs_x[bx].size} !== {32'h3, 3'd0}) begin errors++; $display("FAIL misalign_addr_kept: got %h/%0d want 3/0", obs_x[bx].addr, obs_x[bx].size); end
    end
    checks++; if (obs_r.size() - br != (ACK ? 3 : 2)) begin errors++; $display("FAIL misalign_nresp: got %0d want %0d", obs_r.size() - br, ACK ? 3 : 2); end
    else begin
      checks++; if (obs_r[br] !== {1'b1, 32'h0}) begin errors++; $display("FAIL misalign_resp: got %h want 100000000", obs_r[br]); end
      for (int i = 1; i < obs_r.size() - br; i++) begin
        checks++; if (obs_r[br+i] !== exp_r[er+i]) begin errors++; $display("FAIL misalign_resp%0d: got %h want %h", i, obs_r[br+i], exp_r[er+i]); end
      end
    end
    checks++; if (err_sticky !== 1'b1) begin errors++; $display("FAIL misalign_err: got %b want 1", err_sticky); end
  endtask

  task automatic test_wrap();
    int bx;
    bit ok;
    step();
    bx = obs_x.size();
    send(5, 0); send(1, 32'hFFFF_FFFC); send(2, 32'h6); send(4, 0); send(4, 0);
    drain(ok);
    checks++; if (obs_x.size() - bx != 2) begin errors++; $display("FAIL wrap_nxfer: got %0d want 2", obs_x.size() - bx); end
    else begin
      checks++; if (obs_x[bx].addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_first: got %h want fffffffc", obs_x[bx].addr); end
      checks++; if (obs_x[bx+1].addr !== 32'h0) begin errors++; $display("FAIL wrap_second: got %h want 0", obs_x[bx+1].addr); end
    end
    checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL wrap_err: got %b want 0", err_sticky); end
  endtask

  task automatic test_random();
    int bx, br, ex, er, r;
    logic [31:0] p;
    bit ok;
    for (int b = 0; b < 4; b++) begin
      step();
      err_mode = ($urandom_range(0, 3) == 0);
      waits = $urandom_range(0, 2);
      bx = obs_x.size(); br = obs_r.size(); ex = exp_x.size(); er = exp_r.size();
      for (int n = 0; n < 24; n++) begin
        r = $urandom_range(0, 99);
        p = $urandom;
        if (r < 15) begin
          case ($urandom_range(0, 3))
            0: ;
            3: p = 32'hFFFF_FFF0 + $urandom_range(0, 15);
            default: p = $urandom_range(0, 1023);
          endcase
          send(1, p);
        end
        else if (r < 30) send(2, p & 32'h7);
        else if (r < 55) send(3, p);
        else if (r < 85) send(4, 0);
        else if (r < 92) send(5, 0);
        else send(($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom_range(6, 15)), p);
      end
      drain(ok);
      checks++; if (!ok) begin errors++; $display("FAIL rand%0d_timeout: got busy want idle", b); end
      checks++; if (obs_x.size() - bx != exp_x.size() - ex) begin errors++; $display("FAIL rand%0d_nxfer: got %0d want %0d", b, obs_x.size() - bx, exp_x.size() - ex); end
      else for (int i = 0; i < obs_x.size() - bx; i++) begin
        checks++; if (obs_x[bx+i] !== exp_x[ex+i]) begin errors++; $display("FAIL rand%0d_xfer%0d: got %h want %h", b, i, obs_x[bx+i], exp_x[ex+i]); end
      end
      checks++; if (obs_r.size() - br != exp_r.size() - er) begin errors++; $display("FAIL rand%0d_nresp: got %0d want %0d", b, obs_r.size() - br, exp_r.size() - er); end
      else for (int i = 0; i < obs_r.size() - br; i++) begin
        checks++; if (obs_r[br+i] !== exp_r[er+i]) begin errors++; $display("FAIL rand%0d_resp%0d: got %h want %h", b, i, obs_r[br+i], exp_r[er+i]); end
      end
      checks++; if (err_sticky !== m_err) begin errors++; $display("FAIL rand%0d_err: got %b want %b", b, err_sticky, m_err); end
    end
    err_mode = 0; waits = 0;
  endtask

  task automatic test_backpressure_reset();
    int br, er;
    bit ok;
    step();
    br = obs_r.size(); er = exp_r.size();
    send(5, 0); send(2, 32'h2); send(1, 32'h40);
    wfull = 1'b1;
    send(4, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if (winc !== 1'b0) begin errors++; $display("FAIL bp_winc_held: got %b want 0", winc); end
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy: got %b want 1", busy); end
    step();
    wfull = 1'b0;
    @(negedge clk);
    checks++; if ({winc, wdata_fifo2} !== {1'b1, exp_r[er]}) begin errors++; $display("FAIL bp_release: got %b/%h want 1/%h", winc, wdata_fifo2, exp_r[er]); end
    drain(ok);
    checks++; if (obs_r.size() - br != 1) begin errors++; $display("FAIL bp_nresp: got %0d want 1", obs_r.size() - br); end
    step();
    send(4'hF, 0); send(4, 0);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (HTRANS == 2'b10) begin ok = 1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL rst_no_nonseq: got idle want NONSEQ"); end
    checks++; if (err_sticky !== 1'b1) begin errors++; $display("FAIL rst_pre_err: got %b want 1", err_sticky); end
    #1 rst = 1'b1;
    #1;
    checks++; if ({HTRANS, busy, err_sticky, winc, rinc} !== 6'b0) begin errors++; $display("FAIL rst_async: got %b want 000000", {HTRANS, busy, err_sticky, winc, rinc}); end
    checks++; if (HADDR !== 32'h0) begin errors++; $display("FAIL rst_haddr: got %h want 0", HADDR); end
    step();
    rst = 1'b0;
    model_reset();
    step();
    br = obs_r.size();
    send(3, 32'h0000_0123);
    drain(ok);
    checks++; if (obs_r.size() - br != (ACK ? 1 : 0)) begin errors++; $display("FAIL wr_ack_count: got %0d want %0d", obs_r.size() - br, ACK ? 1 : 0); end
`ifdef AHB_AP_WRITE_ACK_EN
    else begin
      checks++; if (obs_r[br] !== 33'h0) begin errors++; $display("FAIL wr_ack_value: got %h want 0", obs_r[br]); end
    end
`endif
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_latency();
    test_wait_states();
    test_error();
    test_misaligned();
    test_wrap();
    test_random();
    test_backpressure_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
